// File: rtl/sfpp_link_seq_pkg.sv
// sfpp_link_seq_pkg
// Shared types and constants for the SFP+ link sequencer:
//   - sfpp_link_seq_state_t : 3-bit sequencer state (also the seq_state readback code)
//   - GT_*                  : bit positions inside gt_status
//   - CTL_*                 : bit positions inside gt_control
//   - CTRL_*                : gt_control value driven in each state
//   - ctrl_for_state()      : state -> gt_control mapping
// The RX-only and full reset pulses share one state code (ST_RST) so the state
// fits three bits; gt_control (6'h08 vs 6'h01) tells the two apart on readback.
package sfpp_link_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_PLL  = 3'd1,
        ST_WAIT_TX   = 3'd2,
        ST_WAIT_RX   = 3'd3,
        ST_WAIT_LOCK = 3'd4,
        ST_UP        = 3'd5,
        ST_RST       = 3'd6,
        ST_FAULT     = 3'd7
    } sfpp_link_seq_state_t;

    localparam int GT_POWERGOOD         = 0;
    localparam int GT_TX_RESET_DONE     = 4;
    localparam int GT_RX_RESET_DONE     = 7;
    localparam int GT_USERCLK_TX_ACTIVE = 8;
    localparam int GT_USERCLK_RX_ACTIVE = 9;
    localparam int GT_EXT_PLL_LOCK      = 10;
    localparam int GT_QPLL_LOCK         = 11;
    localparam int GT_RX_CDR_STABLE     = 12;

    localparam int CTL_HOLD_ALL   = 0;
    localparam int CTL_TX_PLL_DP  = 1;
    localparam int CTL_RX_PLL_DP  = 2;
    localparam int CTL_RX_DP      = 3;
    localparam int CTL_TX_USERCLK = 4;
    localparam int CTL_RX_USERCLK = 5;

    localparam logic [5:0] CTRL_IDLE     = 6'b1 << CTL_HOLD_ALL;
    localparam logic [5:0] CTRL_RUN      = 6'h00;
    localparam logic [5:0] CTRL_RX_RST   = 6'b1 << CTL_RX_DP;
    localparam logic [5:0] CTRL_FULL_RST = 6'b1 << CTL_HOLD_ALL;
    localparam logic [5:0] CTRL_FAULT    = 6'b1 << CTL_HOLD_ALL;

    function automatic logic [5:0] ctrl_for_state(input sfpp_link_seq_state_t st,
                                                  input logic rx_kind);
        logic [5:0] ctrl;
        ctrl = CTRL_RUN;
        case (st)
            ST_IDLE:  ctrl = CTRL_IDLE;
            ST_FAULT: ctrl = CTRL_FAULT;
            ST_RST:   ctrl = rx_kind ? CTRL_RX_RST : CTRL_FULL_RST;
            default:  ctrl = CTRL_RUN;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/sfpp_link_seq_timer.sv
// sfpp_link_seq_timer
// Loadable down-counter. 'load' takes priority; otherwise the count steps down
// once per cycle and holds at zero. 'done' is high while the count is zero.
// Ports:
//   clk, rst_n  : clock, async active-low reset (count resets to 0)
//   load        : load load_value on this edge
//   load_value  : reload value
//   done        : count == 0
module sfpp_link_seq_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/sfpp_link_sequencer.sv
// sfpp_link_sequencer
// Autonomous bring-up / recovery sequencer for the SFP+ 10GBASE-R transceiver.
// Releases resets in order, waits on status milestones, filters PHY block lock,
// and re-runs resets on timeout or link loss with a bounded retry budget.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   enable         : low forces IDLE on the next edge
//   gt_status[12:0]: transceiver status (pre-synchronized)
//   rx_block_lock  : PHY block lock (pre-synchronized)
//   rx_high_ber    : PHY high BER (pre-synchronized)
//   gt_control[5:0]: transceiver reset controls (registered)
//   link_up, fault : registered state flags
//   retry_count    : retries since last UP, saturating
//   seq_state      : state code for readback
// Build option: define SFPP_LINK_SEQ_BER_RECOVERY_EN to treat rx_high_ber as
// a loss of lock (in UP and in the WAIT_LOCK filter). Otherwise it is ignored.
//
// state        | meaning
// IDLE         | holding everything in reset, waiting for enable
// WAIT_PLL     | waiting for powergood, ext PLL lock and QPLL lock
// WAIT_TX      | waiting for TX reset done and TX userclk active
// WAIT_RX      | waiting for RX reset done, RX userclk active and CDR stable
// WAIT_LOCK    | filtering rx_block_lock for LOCK_FILTER_CYCLES
// UP           | link up
// RST          | reset pulse; rx_kind=1 RX datapath only, rx_kind=0 full
// FAULT        | retries exhausted, waiting for enable to drop
module sfpp_link_sequencer #(
    parameter int TIMEOUT_CYCLES     = 1_000_000,
    parameter int RESET_PULSE_CYCLES = 16,
    parameter int MAX_RETRIES        = 3,
    parameter int LOCK_FILTER_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [12:0] gt_status,
    input  logic        rx_block_lock,
    input  logic        rx_high_ber,
    output logic [5:0]  gt_control,
    output logic        link_up,
    output logic        fault,
    output logic [7:0]  retry_count,
    output logic [2:0]  seq_state
);
    import sfpp_link_seq_pkg::*;

    localparam int CNT_MAX = (TIMEOUT_CYCLES > LOCK_FILTER_CYCLES) ? TIMEOUT_CYCLES
                                                                    : LOCK_FILTER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // The timer counts down to zero inclusive, so loading N-1 gives N cycles.
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(RESET_PULSE_CYCLES - 1);
    // The filter loads N and advances one edge after reaching zero, so UP
    // lands LOCK_FILTER_CYCLES+1 edges after lock is first sampled high.
    localparam logic [CNT_W-1:0] FILTER_LOAD  = CNT_W'(LOCK_FILTER_CYCLES);
    localparam logic [7:0] RETRY_LIMIT = (MAX_RETRIES > 255) ? 8'd255 : 8'(MAX_RETRIES);

    sfpp_link_seq_state_t state, state_next;
    logic       rx_kind, rx_kind_next;
    logic [7:0] retry_next;
    logic       tmr_load, tmr_done, filt_load, filt_done;
    logic       want_retry, retry_rx;
    logic       pll_ok, tx_ok, rx_ok, lock_ok;

    assign pll_ok = gt_status[GT_POWERGOOD] & gt_status[GT_EXT_PLL_LOCK] & gt_status[GT_QPLL_LOCK];
    assign tx_ok  = gt_status[GT_TX_RESET_DONE] & gt_status[GT_USERCLK_TX_ACTIVE];
    assign rx_ok  = gt_status[GT_RX_RESET_DONE] & gt_status[GT_USERCLK_RX_ACTIVE]
                  & gt_status[GT_RX_CDR_STABLE];

    logic unused_status;
    assign unused_status = ^{gt_status[3:1], gt_status[6:5]};

`ifdef SFPP_LINK_SEQ_BER_RECOVERY_EN
    assign lock_ok = rx_block_lock & ~rx_high_ber;
`else
    assign lock_ok = rx_block_lock;
    logic unused_ber;
    assign unused_ber = rx_high_ber;
`endif

    always_comb begin
        state_next   = state;
        rx_kind_next = rx_kind;
        retry_next   = retry_count;
        want_retry   = 1'b0;
        retry_rx     = 1'b0;

        case (state)
            ST_IDLE:      if (enable) state_next = ST_WAIT_PLL;
            ST_WAIT_PLL:  if (pll_ok) state_next = ST_WAIT_TX;
                          else if (tmr_done) want_retry = 1'b1;
            ST_WAIT_TX:   if (tx_ok) state_next = ST_WAIT_RX;
                          else if (tmr_done) want_retry = 1'b1;
            ST_WAIT_RX:   if (rx_ok) state_next = ST_WAIT_LOCK;
                          else if (tmr_done) begin
                              want_retry = 1'b1;
                              retry_rx   = 1'b1;
                          end
            ST_WAIT_LOCK: if (filt_done && lock_ok) state_next = ST_UP;
                          else if (tmr_done) begin
                              want_retry = 1'b1;
                              retry_rx   = 1'b1;
                          end
            ST_UP:        if (!lock_ok) begin
                              want_retry = 1'b1;
                              retry_rx   = 1'b1;
                          end
            ST_RST:       if (tmr_done) state_next = rx_kind ? ST_WAIT_RX : ST_WAIT_PLL;
            ST_FAULT:     state_next = ST_FAULT;
            default:      state_next = ST_IDLE;
        endcase

        // A retry that would push the count past the limit becomes FAULT.
        if (want_retry) begin
            if (retry_count >= RETRY_LIMIT) begin
                state_next = ST_FAULT;
            end else begin
                state_next   = ST_RST;
                rx_kind_next = retry_rx;
                retry_next   = (retry_count == 8'hFF) ? retry_count : retry_count + 8'd1;
            end
        end

        if (!enable) state_next = ST_IDLE;

        if (state_next == ST_IDLE || (state_next == ST_UP && state != ST_UP)) begin
            retry_next = 8'd0;
        end
    end

    assign tmr_load  = (state_next != state);
    assign filt_load = (state != ST_WAIT_LOCK) || !lock_ok;

    sfpp_link_seq_timer #(.WIDTH(CNT_W)) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tmr_load),
        .load_value ((state_next == ST_RST) ? PULSE_LOAD : TIMEOUT_LOAD),
        .done       (tmr_done)
    );

    sfpp_link_seq_timer #(.WIDTH(CNT_W)) u_lock_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (filt_load),
        .load_value (FILTER_LOAD),
        .done       (filt_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rx_kind     <= 1'b0;
            retry_count <= 8'd0;
            gt_control  <= CTRL_IDLE;
            link_up     <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_next;
            rx_kind     <= rx_kind_next;
            retry_count <= retry_next;
            gt_control  <= ctrl_for_state(state_next, rx_kind_next);
            link_up     <= (state_next == ST_UP);
            fault       <= (state_next == ST_FAULT);
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_sfpp_link_sequencer.sv
module tb_sfpp_link_sequencer;
    import sfpp_link_seq_pkg::*;

    localparam int T  = 100;
    localparam int P  = 4;
    localparam int MR = 2;
    localparam int L  = 8;

    localparam logic [12:0] PLL_OK = 13'h0C01;
    localparam logic [12:0] TX_OK  = 13'h0110;
    localparam logic [12:0] RX_OK  = 13'h1280;

    logic        clk = 1'b0;
    logic        rst_n, enable, rx_block_lock, rx_high_ber;
    logic [12:0] gt_status;
    logic [5:0]  gt_control;
    logic        link_up, fault;
    logic [7:0]  retry_count;
    logic [2:0]  seq_state;

    always #5 clk = ~clk;

    sfpp_link_sequencer #(
        .TIMEOUT_CYCLES     (T),
        .RESET_PULSE_CYCLES (P),
        .MAX_RETRIES        (MR),
        .LOCK_FILTER_CYCLES (L)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .gt_status     (gt_status),
        .rx_block_lock (rx_block_lock),
        .rx_high_ber   (rx_high_ber),
        .gt_control    (gt_control),
        .link_up       (link_up),
        .fault         (fault),
        .retry_count   (retry_count),
        .seq_state     (seq_state)
    );

    typedef struct {
        string       tag;
        logic [18:0] vec;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out();
        exp_t        e;
        logic [18:0] obs;
        obs = {seq_state, gt_control, link_up, fault, retry_count};
        tests_run++;
        assert (sb.size() != 0) else begin
            tests_failed++;
            $error("FAIL scoreboard_underflow: observed %h, required a queued expectation", obs);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            assert (obs === e.vec) else begin
                tests_failed++;
                $error("FAIL %s: observed st=%0d ctl=%h up=%b flt=%b rc=%0d, expected st=%0d ctl=%h up=%b flt=%b rc=%0d",
                       e.tag, obs[18:16], obs[15:10], obs[9], obs[8], obs[7:0],
                       e.vec[18:16], e.vec[15:10], e.vec[9], e.vec[8], e.vec[7:0]);
            end
        end
    endtask

    // Queue the expectation as the stimulus is applied, then compare once the
    // DUT has had n edges to respond.
    task automatic exp_at(input string tag, input int n, input logic [2:0] st,
                          input logic [5:0] ctl, input logic lu, input logic flt,
                          input logic [7:0] rc);
        exp_t e;
        e.tag = tag;
        e.vec = {st, ctl, lu, flt, rc};
        sb.push_back(e);
        step(n);
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; gt_status = '0;
        rx_block_lock = 1'b0; rx_high_ber = 1'b0;
        exp_at("reset_values", 2, ST_IDLE, 6'h01, 0, 0, 0);
        rst_n = 1'b1;
        exp_at("idle_disabled", 2, ST_IDLE, 6'h01, 0, 0, 0);

        // Nominal bring-up
        enable = 1'b1;
        exp_at("nom_wait_pll", 1, ST_WAIT_PLL, 6'h00, 0, 0, 0);
        gt_status = PLL_OK;
        exp_at("nom_wait_tx", 1, ST_WAIT_TX, 6'h00, 0, 0, 0);
        gt_status = PLL_OK | TX_OK;
        exp_at("nom_wait_rx", 1, ST_WAIT_RX, 6'h00, 0, 0, 0);
        gt_status = PLL_OK | TX_OK | RX_OK;
        exp_at("nom_wait_lock", 1, ST_WAIT_LOCK, 6'h00, 0, 0, 0);
        rx_block_lock = 1'b1;
        exp_at("nom_filter_edge8", 8, ST_WAIT_LOCK, 6'h00, 0, 0, 0);
        exp_at("nom_up_edge9", 1, ST_UP, 6'h00, 1, 0, 0);

        // One-cycle lock drop -> RX reset pulse -> relock
        rx_block_lock = 1'b0;
        exp_at("drop_rx_rst", 1, ST_RST, 6'h08, 0, 0, 1);
        rx_block_lock = 1'b1;
        exp_at("drop_rx_rst_last", 3, ST_RST, 6'h08, 0, 0, 1);
        exp_at("drop_wait_rx", 1, ST_WAIT_RX, 6'h00, 0, 0, 1);
        exp_at("drop_wait_lock", 1, ST_WAIT_LOCK, 6'h00, 0, 0, 1);
        exp_at("drop_filter", 8, ST_WAIT_LOCK, 6'h00, 0, 0, 1);
        exp_at("drop_relock_up", 1, ST_UP, 6'h00, 1, 0, 0);

        // High BER in UP
        rx_high_ber = 1'b1;
`ifdef SFPP_LINK_SEQ_BER_RECOVERY_EN
        exp_at("ber_rx_rst", 1, ST_RST, 6'h08, 0, 0, 1);
        rx_high_ber = 1'b0;
        exp_at("ber_wait_rx", 4, ST_WAIT_RX, 6'h00, 0, 0, 1);
        exp_at("ber_relock_up", 10, ST_UP, 6'h00, 1, 0, 0);
`else
        exp_at("ber_ignored", 1, ST_UP, 6'h00, 1, 0, 0);
        rx_high_ber = 1'b0;
`endif

        // Lock glitch at filter cycle 6 restarts the filter
        rx_block_lock = 1'b0;
        exp_at("glitch_rx_rst", 1, ST_RST, 6'h08, 0, 0, 1);
        rx_block_lock = 1'b1;
        exp_at("glitch_wait_lock", 5, ST_WAIT_LOCK, 6'h00, 0, 0, 1);
        step(6);
        rx_block_lock = 1'b0;
        step(1);
        rx_block_lock = 1'b1;
        exp_at("glitch_restarted", 8, ST_WAIT_LOCK, 6'h00, 0, 0, 1);
        exp_at("glitch_up", 1, ST_UP, 6'h00, 1, 0, 0);

        // No lock at all: WAIT_LOCK timeouts exhaust retries
        rx_block_lock = 1'b0;
        exp_at("nolock_rx_rst", 1, ST_RST, 6'h08, 0, 0, 1);
        exp_at("nolock_wait_lock", 5, ST_WAIT_LOCK, 6'h00, 0, 0, 1);
        exp_at("nolock_cycle99", T - 1, ST_WAIT_LOCK, 6'h00, 0, 0, 1);
        exp_at("nolock_timeout", 1, ST_RST, 6'h08, 0, 0, 2);
        exp_at("nolock_wait_lock2", 5, ST_WAIT_LOCK, 6'h00, 0, 0, 2);
        exp_at("nolock_fault", T, ST_FAULT, 6'h01, 0, 1, 2);
        exp_at("fault_sticky", 5, ST_FAULT, 6'h01, 0, 1, 2);
        enable = 1'b0;
        exp_at("fault_to_idle", 1, ST_IDLE, 6'h01, 0, 0, 0);

        // QPLL never locks: full reset pulses, then FAULT
        gt_status = PLL_OK | TX_OK | RX_OK;
        gt_status[11] = 1'b0;
        enable = 1'b1;
        exp_at("qpll_wait_pll", 1, ST_WAIT_PLL, 6'h00, 0, 0, 0);
        exp_at("qpll_cycle99", T - 1, ST_WAIT_PLL, 6'h00, 0, 0, 0);
        exp_at("qpll_full_rst1", 1, ST_RST, 6'h01, 0, 0, 1);
        exp_at("qpll_full_rst1_last", P - 1, ST_RST, 6'h01, 0, 0, 1);
        exp_at("qpll_back_wait_pll", 1, ST_WAIT_PLL, 6'h00, 0, 0, 1);
        exp_at("qpll_full_rst2", T, ST_RST, 6'h01, 0, 0, 2);
        exp_at("qpll_back_wait_pll2", P, ST_WAIT_PLL, 6'h00, 0, 0, 2);
        exp_at("qpll_fault", T, ST_FAULT, 6'h01, 0, 1, 2);
        enable = 1'b0;
        exp_at("qpll_idle", 1, ST_IDLE, 6'h01, 0, 0, 0);

        // Advance and timeout in the same cycle: advance wins
        enable = 1'b1;
        exp_at("race_wait_pll", 1, ST_WAIT_PLL, 6'h00, 0, 0, 0);
        step(T - 1);
        gt_status[11] = 1'b1;
        exp_at("race_advance_wins", 1, ST_WAIT_TX, 6'h00, 0, 0, 0);
        enable = 1'b0;
        exp_at("enable_drop_idle", 1, ST_IDLE, 6'h01, 0, 0, 0);

        // Async reset in the middle of an RX reset pulse
        enable = 1'b1;
        rx_block_lock = 1'b1;
        exp_at("rebring_up", 4 + L + 1, ST_UP, 6'h00, 1, 0, 0);
        rx_block_lock = 1'b0;
        exp_at("pre_async_rx_rst", 1, ST_RST, 6'h08, 0, 0, 1);
        rx_block_lock = 1'b1;
        #2;
        rst_n = 1'b0;
        exp_at("async_reset_now", 0, ST_IDLE, 6'h01, 0, 0, 0);
        exp_at("async_reset_held", 2, ST_IDLE, 6'h01, 0, 0, 0);
        rst_n = 1'b1;
        exp_at("restart_from_idle", 1, ST_WAIT_PLL, 6'h00, 0, 0, 0);

        tests_run++;
        assert (sb.size() == 0) else begin
            tests_failed++;
            $error("FAIL scoreboard_drain: observed %0d leftover entries, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sfpp_link_sequencer.md
# sfpp_link_sequencer

Autonomous bring-up and recovery sequencer for the SFP+ 10GBASE-R transceiver and PHY. It drives the six transceiver control bits in place of manual Wishbone writes: release resets in order, wait for each status milestone, confirm PHY block lock, and re-run resets on timeout or link loss. Retries are bounded and the block reports a fault when they run out. It sits beside the SFP+ transceiver/PHY wrapper in the `wb.clk` domain; the parent synchronizes all status inputs into `clk`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1_000_000: wait budget per waiting state, in `clk` cycles.
- `RESET_PULSE_CYCLES`, 16: length of every reset pulse the block issues.
- `MAX_RETRIES`, 3: number of timeouts/recoveries allowed before FAULT.
- `LOCK_FILTER_CYCLES`, 1024: number of consecutive cycles `rx_block_lock` must stay high before the link is declared up.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  sequencing enabled; low forces IDLE.
- `gt_status`  in  13  transceiver status. Bit 0 powergood, 4 tx_reset_done, 7 rx_reset_done, 8 userclk_tx_active, 9 userclk_rx_active, 10 ext PLL lock, 11 QPLL lock, 12 rx_cdr_stable. All bits are pre-synchronized to `clk`.
- `rx_block_lock`  in  1  PHY block lock, synchronized to `clk`.
- `rx_high_ber`  in  1  PHY high BER, synchronized to `clk`.
- `gt_control`  out  6  transceiver control. Bit 0 hold-all reset, 1 TX PLL+datapath, 2 RX PLL+datapath, 3 RX datapath, 4 TX userclk, 5 RX userclk.
- `link_up`  out  1  high only in state UP.
- `fault`  out  1  high only in state FAULT.
- `retry_count`  out  8  retries since the last UP, saturating at 255.
- `seq_state`  out  3  current state encoding, for Wishbone readback.

## Operation
- States, with `gt_control` in each:
  - IDLE: 6'h01.
  - WAIT_PLL: 0.
  - WAIT_TX: 0.
  - WAIT_RX: 0.
  - WAIT_LOCK: 0.
  - UP: 0.
  - RX_RST: 6'h08.
  - FULL_RST: 6'h01.
  - FAULT: 6'h01.
- IDLE → WAIT_PLL when `enable`=1.
- WAIT_PLL → WAIT_TX when bits 0, 10 and 11 are all high.
- WAIT_TX → WAIT_RX when bits 4 and 8 are high.
- WAIT_RX → WAIT_LOCK when bits 7, 9 and 12 are high.
- WAIT_LOCK → UP after `rx_block_lock` has been high for LOCK_FILTER_CYCLES consecutive cycles. Any low cycle restarts the filter count; the timeout count is not restarted.
- UP: `rx_block_lock` low for one cycle → RX_RST.
- Timeouts:
  - In WAIT_PLL or WAIT_TX → FULL_RST.
  - In WAIT_RX or WAIT_LOCK → RX_RST.
- RX_RST lasts RESET_PULSE_CYCLES, then → WAIT_RX.
- FULL_RST lasts RESET_PULSE_CYCLES, then → WAIT_PLL.
- `retry_count`:
  - Increments on every entry to RX_RST or FULL_RST.
  - Cleared on entry to UP and to IDLE.
- Retry limit: any entry into RX_RST or FULL_RST that would make `retry_count` exceed MAX_RETRIES goes to FAULT instead, and the count is not incremented.
- FAULT is left only when `enable` goes low (→ IDLE).
- `enable`=0 in any state → IDLE on the next edge. This overrides every other transition.

## Timing
- Reset values:
  - `seq_state` = IDLE
  - `gt_control` = 6'h01
  - `link_up` = 0
  - `fault` = 0
  - `retry_count` = 0
  - all internal counters = 0
- All outputs are registered. `gt_control`, `link_up` and `fault` change on the same edge as the state register.
- Transition latency: one edge after the qualifying input is sampled.
- The timer reloads on every state entry.
- Timeout fires after exactly TIMEOUT_CYCLES cycles in the state. The transition occurs on the edge that completes the TIMEOUT_CYCLES-th cycle.
- If the advance condition and the timeout are true in the same cycle, the advance wins.
- Reset pulse width is exactly RESET_PULSE_CYCLES cycles of `gt_control` asserted.
- Counter widths: `$clog2(max(TIMEOUT_CYCLES, LOCK_FILTER_CYCLES)+1)`.
- An asynchronous `rst_n` assertion mid-sequence forces the reset values immediately. The sequence restarts from IDLE after release.

## Configuration
- `SFPP_LINK_SEQ_BER_RECOVERY_EN`
  - Defined: in UP, `rx_high_ber`=1 for one cycle → RX_RST, counted like a link drop. The condition is also treated as a loss of lock in the WAIT_LOCK filter.
  - Undefined: `rx_high_ber` is ignored; the port remains and is unused.

## Structure
- Package `sfpp_link_seq_pkg` holds:
  - the state enum `sfpp_link_seq_state_t` (3 bits)
  - localparams for status bit indices
  - localparams for control bit indices
  - the control constants for each state
- Sub-module `sfpp_link_seq_timer`: a loadable down-counter with a `done` flag. It is instanced once for timeout/pulse timing and once for the lock filter.

## Test plan
Bench parameters: TIMEOUT_CYCLES=100, RESET_PULSE_CYCLES=4, MAX_RETRIES=2, LOCK_FILTER_CYCLES=8.

- Nominal bring-up: release reset, `enable`=1, raise the status milestones in order, hold lock → `gt_control` is 0 from WAIT_PLL onward; `link_up`=1 exactly 9 edges after `rx_block_lock` rises; `retry_count`=0.
- QPLL never locks → FULL_RST (`gt_control`=6'h01 for 4 cycles) at cycle 100 of WAIT_PLL, twice. The third timeout → FAULT with `fault`=1 and `retry_count`=2. `enable`=0 → IDLE and `retry_count`=0.
- Link up, then drop `rx_block_lock` for one cycle → RX_RST (`gt_control`=6'h08 for 4 cycles), then WAIT_RX; `retry_count`=1. Re-lock → UP and `retry_count`=0.
- Lock glitch at filter cycle 6 → filter restarts; UP is reached 8 cycles after the glitch. With no lock at all → RX_RST at cycle 100 of WAIT_LOCK.
- `rx_high_ber`=1 in UP → RX_RST with the macro defined; no state change with the macro undefined.
- `rst_n` asserted during RX_RST and `enable` dropped during WAIT_TX → all outputs return to their reset values; IDLE next edge.
